// File: rtl/packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : packet_receiver
// Purpose  : RGMII receive path - strips preamble, filters dest MAC, checks
//            FCS and holds one good frame in a byte buffer for the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module packet_receiver #(
  parameter int          AW       = 11,
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [7:0]    rx_data,
  input  logic [1:0]    rx_ctl,
  output logic          frame_valid,
  output logic [AW-1:0] frame_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frame_ack,
  output logic [7:0]    err_count,
  output logic [7:0]    drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DISCARD} state_t;

  localparam logic [AW:0]  c_min_frame = (AW+1)'(64);
  localparam logic [AW:0]  c_fcs_len   = (AW+1)'(4);
  localparam logic [AW:0]  c_last_dest = (AW+1)'(5);
  localparam logic [AW:0]  c_dest_len  = (AW+1)'(6);
  localparam logic [AW:0]  c_one       = (AW+1)'(1);
  localparam logic [31:0]  c_crc_init  = 32'hFFFF_FFFF;
  localparam logic [31:0]  c_crc_resid = 32'hDEBB_20E3;

  state_t      r_state, w_state_nxt;
  logic [AW:0] r_wcnt;
  logic [31:0] r_crc;
  logic        r_uc_ok, r_bc_ok;
  logic [7:0]  r_mem [0:(1<<AW)-1];

  logic        w_dv, w_er, w_free, w_in_dest, w_uc_hit, w_bc_hit;
  logic        w_wr, w_err_inc, w_drop_inc, w_accept;
  logic [47:0] w_mac_shift;
  logic [AW:0] w_len_full;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    return x;
  endfunction

  assign w_dv        = rx_ctl[0];
  assign w_er        = rx_ctl[0] ^ rx_ctl[1];
  // Acknowledge on the SFD edge frees the buffer for the incoming frame.
  assign w_free      = !frame_valid || frame_ack;
  assign w_in_dest   = (r_wcnt < c_dest_len);
  assign w_mac_shift = MAC_ADDR >> {(3'd5 - r_wcnt[2:0]), 3'b000};
  assign w_uc_hit    = !w_in_dest || (rx_data == w_mac_shift[7:0]);
  assign w_bc_hit    = !w_in_dest || (rx_data == 8'hFF);
  assign w_len_full  = r_wcnt - c_fcs_len;

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_err_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dv) w_state_nxt = (rx_data == 8'h55) ? S_PRE : S_DISCARD;
      end
      S_PRE: begin
        if (!w_dv)                  w_state_nxt = S_IDLE;
        else if (rx_data == 8'h55)  w_state_nxt = S_PRE;
        else if (rx_data == 8'hD5) begin
          if (w_free) w_state_nxt = S_DATA;
          else begin
            w_state_nxt = S_DISCARD;
            w_drop_inc  = 1'b1;
          end
        end
        else                        w_state_nxt = S_DISCARD;
      end
      S_DATA: begin
        if (!w_dv) begin
          w_state_nxt = S_IDLE;
          if (r_wcnt < c_min_frame)       w_err_inc = 1'b1;
          else if (r_crc != c_crc_resid)  w_err_inc = 1'b1;
          else                            w_accept  = 1'b1;
        end else if (w_er) begin
          w_state_nxt = S_DISCARD;
          w_err_inc   = 1'b1;
        end else if (r_wcnt[AW]) begin
          w_state_nxt = S_DISCARD;
          w_drop_inc  = 1'b1;
        end else begin
          w_wr = 1'b1;
          if (r_wcnt == c_last_dest && !(r_uc_ok && w_uc_hit) && !(r_bc_ok && w_bc_hit))
            w_state_nxt = S_DISCARD;
        end
      end
      default: begin
        if (!w_dv) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_crc       <= c_crc_init;
      r_uc_ok     <= 1'b1;
      r_bc_ok     <= 1'b1;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      err_count   <= 8'h00;
      drop_count  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != S_DATA) begin
        r_wcnt  <= '0;
        r_crc   <= c_crc_init;
        r_uc_ok <= 1'b1;
        r_bc_ok <= 1'b1;
      end else if (w_wr) begin
        r_wcnt  <= r_wcnt + c_one;
        r_crc   <= crc_byte(r_crc, rx_data);
        r_uc_ok <= r_uc_ok && w_uc_hit;
        r_bc_ok <= r_bc_ok && w_bc_hit;
      end
      if (w_accept) begin
        frame_valid <= 1'b1;
        frame_len   <= w_len_full[AW-1:0];
      end else if (frame_ack) begin
        frame_valid <= 1'b0;
      end
      if (w_err_inc && err_count != 8'hFF)   err_count  <= err_count + 8'd1;
      if (w_drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wcnt[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rd_data <= 8'h00;
    else         rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_receiver
// Purpose  : Randomized scoreboard bench for packet_receiver (AW=7 buffer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_receiver;
  localparam int          AW  = 7;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTH = 48'h02_00_00_00_00_02;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0, nreset = 1'b0, frame_ack = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [1:0]    rx_ctl = 2'b00;
  logic [AW-1:0] rd_addr = '0;
  logic          frame_valid;
  logic [AW-1:0] frame_len;
  logic [7:0]    rd_data, err_count, drop_count;

  int errors = 0, checks = 0;
  bit m_valid = 0;
  int m_len = 0, m_err = 0, m_drop = 0;
  bq_t m_buf;
  int exp_len_q[$];
  logic [7:0] exp_rd_q[$];
  logic rd_req = 1'b0, rd_req_d = 1'b0, prev_valid = 1'b0;

  packet_receiver #(.AW(AW), .MAC_ADDR(MAC)) dut (
    .clk(clk), .nreset(nreset), .rx_data(rx_data), .rx_ctl(rx_ctl),
    .frame_valid(frame_valid), .frame_len(frame_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_ack(frame_ack), .err_count(err_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: read data and newly presented frames
  always @(posedge clk) rd_req_d <= rd_req;
  always @(negedge clk) begin
    if (rd_req_d) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %0h expected none", rd_data);
      end else chk("rd_data", {24'h0, rd_data}, {24'h0, exp_rd_q.pop_front()});
    end
    if (frame_valid && !prev_valid) begin
      if (exp_len_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_unexpected: got len %0d expected no frame", frame_len);
      end else chk("frame_len_sb", {25'h0, frame_len}, exp_len_q.pop_front());
    end
    prev_valid = frame_valid;
  end

  // Standard Ethernet CRC-32 of the first n bytes (FCS value as transmitted)
  function automatic logic [31:0] crc32(bq_t f, int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = ((c[0] ^ f[i][b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return ~c;
  endfunction

  task automatic build(output bq_t f, input logic [47:0] dest, input int n, input bit bad_fcs);
    logic [31:0] c;
    f.delete();
    for (int i = 0; i < 6; i++) f.push_back(dest[47-8*i -: 8]);
    for (int i = 6; i < n - 4; i++) f.push_back(8'($urandom));
    c = crc32(f, n - 4);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (bad_fcs) f[n-2] = f[n-2] ^ 8'h5A;
  endtask

  // Reference model: outcome of one frame from the receive rules
  task automatic model(bq_t f, int er_idx, bit ack_sfd);
    int n = f.size();
    logic [47:0] d;
    logic [31:0] c;
    if (ack_sfd) m_valid = 0;
    if (m_valid) begin if (m_drop < 255) m_drop++; return; end
    for (int i = 0; i < n; i++) begin
      if (i == er_idx) begin if (m_err < 255) m_err++; return; end
      if (i >= (1 << AW)) begin if (m_drop < 255) m_drop++; return; end
      if (i == 5) begin
        d = {f[0], f[1], f[2], f[3], f[4], f[5]};
        if (d != MAC && d != BC) return;
      end
    end
    if (n < 64) begin if (m_err < 255) m_err++; return; end
    c = crc32(f, n - 4);
    if ({f[n-1], f[n-2], f[n-3], f[n-4]} != c) begin if (m_err < 255) m_err++; return; end
    m_valid = 1; m_len = n - 4; m_buf = f;
    exp_len_q.push_back(n - 4);
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] c, input logic ack);
    @(negedge clk);
    rx_data = d; rx_ctl = c; frame_ack = ack;
  endtask

  task automatic send(bq_t f, int er_idx, bit ack_sfd);
    for (int i = 0; i < 7; i++) drive(8'h55, 2'b11, 1'b0);
    drive(8'hD5, 2'b11, ack_sfd);
    for (int i = 0; i < f.size(); i++) drive(f[i], (i == er_idx) ? 2'b01 : 2'b11, 1'b0);
    drive(8'h00, 2'b00, 1'b0);
    model(f, er_idx, ack_sfd);
    @(negedge clk);
    chk("frame_valid", {31'h0, frame_valid}, {31'h0, m_valid});
    chk("err_count", {24'h0, err_count}, m_err);
    chk("drop_count", {24'h0, drop_count}, m_drop);
    if (m_valid) chk("frame_len", {25'h0, frame_len}, m_len);
  endtask

  task automatic read_check(int n);
    for (int a = 0; a < n; a++) begin
      @(negedge clk);
      rd_addr = AW'(a); rd_req = 1'b1;
      exp_rd_q.push_back(m_buf[a]);
    end
    @(negedge clk); rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_frame();
    @(negedge clk); frame_ack = 1'b1;
    @(negedge clk); frame_ack = 1'b0;
    m_valid = 0;
    chk("valid_after_ack", {31'h0, frame_valid}, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    int n, er;
    logic [47:0] dst;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, frame_valid}, 32'h0);
    chk("rst_len", {25'h0, frame_len}, 32'h0);
    chk("rst_err", {24'h0, err_count}, 32'h0);
    chk("rst_drop", {24'h0, drop_count}, 32'h0);
    chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    build(f, MAC, 64, 0);  send(f, -1, 0); read_check(60); ack_frame();
    build(f, BC, 100, 0);  send(f, -1, 0); read_check(96); ack_frame();
    build(f, OTH, 64, 0);  send(f, -1, 0);
    build(f, MAC, 80, 1);  send(f, -1, 0);
    build(f, MAC, 40, 0);  send(f, -1, 0);
    build(f, MAC, 80, 0);  send(f, 20, 0);

    // Busy buffer: second frame dropped, held frame untouched; then ack on SFD
    build(f, MAC, 70, 0);  send(f, -1, 0);
    build(f, BC, 90, 0);   send(f, -1, 0); read_check(m_len);
    build(f, MAC, 110, 0); send(f, -1, 1); read_check(m_len); ack_frame();

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       dst = MAC;
        1:       dst = BC;
        default: dst = OTH;
      endcase
      n  = $urandom_range(40, 128);
      er = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      build(f, dst, n, $urandom_range(0, 3) == 0);
      send(f, er, 0);
      if (m_valid) begin read_check(m_len); ack_frame(); end
    end

    build(f, MAC, 130, 0); send(f, -1, 0);
    for (int k = 0; k < 300; k++) begin build(f, BC, 130, 0); send(f, -1, 0); end
    chk("drop_saturated", {24'h0, drop_count}, 32'hFF);

    // Reset mid-frame
    build(f, MAC, 64, 0);
    for (int i = 0; i < 7; i++) drive(8'h55, 2'b11, 1'b0);
    drive(8'hD5, 2'b11, 1'b0);
    for (int i = 0; i < 20; i++) drive(f[i], 2'b11, 1'b0);
    @(negedge clk); nreset = 1'b0;
    #1;
    m_valid = 0; m_len = 0; m_err = 0; m_drop = 0;
    chk("mid_rst_valid", {31'h0, frame_valid}, 32'h0);
    chk("mid_rst_len", {25'h0, frame_len}, 32'h0);
    chk("mid_rst_err", {24'h0, err_count}, 32'h0);
    chk("mid_rst_drop", {24'h0, drop_count}, 32'h0);
    chk("mid_rst_rd_data", {24'h0, rd_data}, 32'h0);
    @(negedge clk); nreset = 1'b1; rx_ctl = 2'b00;
    @(negedge clk);
    build(f, MAC, 72, 0); send(f, -1, 0); read_check(m_len); ack_frame();

    repeat (3) @(negedge clk);
    chk("sb_len_empty", exp_len_q.size(), 32'h0);
    chk("sb_rd_empty", exp_rd_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
